// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-ported, request/ack memory between the instruction-fetch
// (read-only) and data (read/write) requesters, with starvation guard and transaction timeout.
module unified_mem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  output logic              i_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              d_stall,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [7:0] TO_LAST    = 8'(TIMEOUT - 1);
  localparam bit         TO_EN      = (TIMEOUT != 0);

  state_t     state_q, state_d;
  logic [3:0] starve_q;
  logic [7:0] to_q;
  logic       i_eff, d_eff;
  logic       grant_i, grant_d, timed_out, busy;

  assign i_stall = i_req & ~i_ready;
  assign d_stall = d_req & ~d_ready;

  always_comb begin
    state_d   = state_q;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    timed_out = 1'b0;
    busy      = 1'b0;
    // A requester seeing its ready pulse still holds req this cycle; don't grant it again.
    i_eff     = i_req & ~i_ready;
    d_eff     = d_req & ~d_ready;
    case (state_q)
      IDLE: begin
        if (i_eff && (starve_q == STARVE_MAX)) grant_i = 1'b1;
        else if (d_eff)                        grant_d = 1'b1;
        else if (i_eff)                        grant_i = 1'b1;
        if (grant_i)      state_d = I_BUSY;
        else if (grant_d) state_d = D_BUSY;
      end
      I_BUSY, D_BUSY: begin
        busy = 1'b1;
        // An ack on the final allowed cycle wins over the abort.
        if (mem_ack) begin
          state_d = IDLE;
        end else if (TO_EN && (to_q == TO_LAST)) begin
          timed_out = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      to_q      <= '0;
      i_rdata   <= '0;
      i_ready   <= 1'b0;
      d_rdata   <= '0;
      d_ready   <= 1'b0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state_q <= state_d;
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      err     <= 1'b0;

      if (grant_i || !i_req)          starve_q <= '0;
      else if (starve_q < STARVE_MAX) starve_q <= starve_q + 4'd1;

      if (grant_i || grant_d) begin
        mem_req   <= 1'b1;
        mem_we    <= grant_d & d_we;
        mem_addr  <= grant_d ? d_addr : i_addr;
        mem_wdata <= grant_d ? d_wdata : '0;
        to_q      <= '0;
      end else if (busy) begin
        if (mem_ack || timed_out) begin
          mem_req <= 1'b0;
          err     <= timed_out;
          if (state_q == I_BUSY) begin
            i_ready <= 1'b1;
            i_rdata <= timed_out ? '0 : mem_rdata;
          end else begin
            d_ready <= 1'b1;
            if (timed_out)    d_rdata <= '0;
            else if (!mem_we) d_rdata <= mem_rdata;
          end
        end else begin
          to_q <= to_q + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: directed vector table, hand-written
// corner sequences, and a randomized run against a transaction-level reference model.
module tb_unified_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SL = 4;
  localparam int unsigned TO = 8;

  logic          clk;
  logic          reset;
  logic          i_req, i_ready, i_stall;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_we, d_ready, d_stall;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          err, mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready), .i_stall(i_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_ready(d_ready), .d_stall(d_stall), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic inputs_idle();
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
  endtask

  task automatic chk_out(input string tag,
                         input logic emr, input logic emw, input logic [31:0] ema,
                         input logic [31:0] emd, input logic eir, input logic edr,
                         input logic eer, input logic [31:0] eird, input logic [31:0] edrd);
    chk({tag, ".mem_req"},   mem_req,   emr);
    chk({tag, ".mem_we"},    mem_we,    emw);
    chk({tag, ".mem_addr"},  mem_addr,  ema);
    chk({tag, ".mem_wdata"}, mem_wdata, emd);
    chk({tag, ".i_ready"},   i_ready,   eir);
    chk({tag, ".d_ready"},   d_ready,   edr);
    chk({tag, ".err"},       err,       eer);
    chk({tag, ".i_rdata"},   i_rdata,   eird);
    chk({tag, ".d_rdata"},   d_rdata,   edrd);
    chk({tag, ".i_stall"},   i_stall,   i_req & ~eir);
    chk({tag, ".d_stall"},   d_stall,   d_req & ~edr);
  endtask

  typedef struct {
    logic        ir;  logic [31:0] ia;
    logic        dr;  logic        dw;  logic [31:0] da; logic [31:0] dd;
    logic        ack; logic [31:0] mr;
    logic        emr; logic        emw; logic [31:0] ema; logic [31:0] emd;
    logic        eir; logic        edr; logic        eer;
    logic [31:0] eird; logic [31:0] edrd;
  } vec_t;

  function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr,
                              input logic dw, input logic [31:0] da, input logic [31:0] dd,
                              input logic ack, input logic [31:0] mr, input logic emr,
                              input logic emw, input logic [31:0] ema, input logic [31:0] emd,
                              input logic eir, input logic edr, input logic eer,
                              input logic [31:0] eird, input logic [31:0] edrd);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
    v.ack = ack; v.mr = mr; v.emr = emr; v.emw = emw; v.ema = ema; v.emd = emd;
    v.eir = eir; v.edr = edr; v.eer = eer; v.eird = eird; v.edrd = edrd;
    return v;
  endfunction

  vec_t tbl[16];

  // reference model state
  int          own;      // 0 none, 1 fetch, 2 data
  bit          own_we;
  int          k;        // busy cycle index, 1-based
  int          dly;      // busy cycle in which the memory will ack (> TO means never)
  int          st;
  logic        e_mr, e_mw, e_ir, e_dr, e_er;
  logic [31:0] e_ma, e_md, e_ird, e_drd;

  task automatic model_reset();
    own = 0; own_we = 1'b0; k = 0; dly = 0; st = 0;
    e_mr = 1'b0; e_mw = 1'b0; e_ir = 1'b0; e_dr = 1'b0; e_er = 1'b0;
    e_ma = '0; e_md = '0; e_ird = '0; e_drd = '0;
  endtask

  initial begin
    int hi, d_since_i, max_d, i_done, d_done;
    bit ip, dp;
    logic [31:0] ia_r, da_r, dd_r;
    logic dw_r;
    logic n_mr, n_mw, n_ir, n_dr, n_er;
    logic [31:0] n_ma, n_md, n_ird, n_drd;
    bit gi, gd, im, dm;

    reset = 1'b0;
    inputs_idle();

    // --- reset state ---
    tick();
    settle();
    chk_out("reset0", '0, '0, '0, '0, '0, '0, '0, '0, '0);
    tick(); tick();
    reset = 1'b1;

    // --- directed table: single fetch, D-vs-I priority with write, spurious acks ---
    tbl[0]  = mk('1, 32'h40, '0, '0, '0, '0, '0, '0,          '0, '0, '0, '0, '0, '0, '0, '0, '0);
    tbl[1]  = mk('1, 32'h40, '0, '0, '0, '0, '0, '0,          '1, '0, 32'h40, '0, '0, '0, '0, '0, '0);
    tbl[2]  = mk('1, 32'h40, '0, '0, '0, '0, '0, '0,          '1, '0, 32'h40, '0, '0, '0, '0, '0, '0);
    tbl[3]  = mk('1, 32'h40, '0, '0, '0, '0, '1, 32'hDEADBEEF, '1, '0, 32'h40, '0, '0, '0, '0, '0, '0);
    tbl[4]  = mk('1, 32'h40, '0, '0, '0, '0, '0, '0,          '0, '0, 32'h40, '0, '1, '0, '0, 32'hDEADBEEF, '0);
    tbl[5]  = mk('0, '0, '0, '0, '0, '0, '0, '0,              '0, '0, 32'h40, '0, '0, '0, '0, 32'hDEADBEEF, '0);
    tbl[6]  = mk('1, 32'h44, '1, '1, 32'h80, 32'h12345678, '0, '0,
                 '0, '0, 32'h40, '0, '0, '0, '0, 32'hDEADBEEF, '0);
    tbl[7]  = mk('1, 32'h44, '1, '1, 32'h80, 32'h12345678, '0, '0,
                 '1, '1, 32'h80, 32'h12345678, '0, '0, '0, 32'hDEADBEEF, '0);
    tbl[8]  = mk('1, 32'h44, '1, '1, 32'h80, 32'h12345678, '1, 32'hCAFEF00D,
                 '1, '1, 32'h80, 32'h12345678, '0, '0, '0, 32'hDEADBEEF, '0);
    tbl[9]  = mk('1, 32'h44, '1, '1, 32'h80, 32'h12345678, '0, '0,
                 '0, '1, 32'h80, 32'h12345678, '0, '1, '0, 32'hDEADBEEF, '0);
    tbl[10] = mk('1, 32'h44, '0, '0, '0, '0, '0, '0,          '1, '0, 32'h44, '0, '0, '0, '0, 32'hDEADBEEF, '0);
    tbl[11] = mk('1, 32'h44, '0, '0, '0, '0, '1, 32'h0BADC0DE, '1, '0, 32'h44, '0, '0, '0, '0, 32'hDEADBEEF, '0);
    tbl[12] = mk('1, 32'h44, '0, '0, '0, '0, '0, '0,          '0, '0, 32'h44, '0, '1, '0, '0, 32'h0BADC0DE, '0);
    tbl[13] = mk('0, '0, '0, '0, '0, '0, '1, 32'h11111111,    '0, '0, 32'h44, '0, '0, '0, '0, 32'h0BADC0DE, '0);
    tbl[14] = mk('0, '0, '0, '0, '0, '0, '1, 32'h22222222,    '0, '0, 32'h44, '0, '0, '0, '0, 32'h0BADC0DE, '0);
    tbl[15] = mk('0, '0, '0, '0, '0, '0, '0, '0,              '0, '0, 32'h44, '0, '0, '0, '0, 32'h0BADC0DE, '0);

    foreach (tbl[r]) begin
      i_req = tbl[r].ir; i_addr = tbl[r].ia;
      d_req = tbl[r].dr; d_we = tbl[r].dw; d_addr = tbl[r].da; d_wdata = tbl[r].dd;
      mem_ack = tbl[r].ack; mem_rdata = tbl[r].mr;
      settle();
      chk_out($sformatf("vec%0d", r), tbl[r].emr, tbl[r].emw, tbl[r].ema, tbl[r].emd,
              tbl[r].eir, tbl[r].edr, tbl[r].eer, tbl[r].eird, tbl[r].edrd);
      tick();
    end
    inputs_idle();

    // --- data read loads d_rdata, then a read that times out ---
    d_req = 1'b1; d_addr = 32'h200;
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hA5A5A5A5;
    tick();
    mem_ack = 1'b0; d_req = 1'b0;
    settle();
    chk("rd.d_ready", d_ready, 1'b1);
    chk("rd.d_rdata", d_rdata, 32'hA5A5A5A5);
    chk("rd.err", err, 1'b0);
    tick();
    d_req = 1'b1; d_addr = 32'h300;
    tick();
    for (int c = 1; c <= 8; c++) begin
      settle();
      chk($sformatf("to.busy%0d.mem_req", c), mem_req, 1'b1);
      tick();
    end
    settle();
    chk("to.mem_req", mem_req, 1'b0);
    chk("to.d_ready", d_ready, 1'b1);
    chk("to.err", err, 1'b1);
    chk("to.d_rdata", d_rdata, 32'h0);
    d_req = 1'b0;
    tick();
    settle();
    chk("to.after.d_ready", d_ready, 1'b0);
    chk("to.after.err", err, 1'b0);

    // --- ack in the very cycle the timeout would fire is a normal completion ---
    d_req = 1'b1; d_addr = 32'h600;
    tick();
    for (int c = 1; c <= 8; c++) begin
      if (c == 8) begin mem_ack = 1'b1; mem_rdata = 32'h5A5A5A5A; end
      settle();
      chk($sformatf("edge.busy%0d.mem_req", c), mem_req, 1'b1);
      tick();
    end
    mem_ack = 1'b0; d_req = 1'b0;
    settle();
    chk("edge.d_ready", d_ready, 1'b1);
    chk("edge.err", err, 1'b0);
    chk("edge.d_rdata", d_rdata, 32'h5A5A5A5A);
    chk("edge.mem_addr", mem_addr, 32'h600);
    tick();

    // --- both requesters saturating the memory: fetch keeps making progress ---
    i_req = 1'b1; i_addr = 32'h1000;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'h0F0F0F0F;
    hi = 0; d_since_i = 0; max_d = 0; i_done = 0; d_done = 0;
    for (int c = 0; c < 72; c++) begin
      if (mem_req) hi++; else hi = 0;
      mem_ack = (hi == 2);
      mem_rdata = $urandom;
      if (d_ready) begin
        d_done++; d_since_i++;
        if (c >= 60) d_req = 1'b0;
        else begin d_addr = d_addr + 32'd4; d_wdata = $urandom; end
      end
      if (i_ready) begin
        i_done++;
        if (d_since_i > max_d) max_d = d_since_i;
        d_since_i = 0;
        if (c >= 60) i_req = 1'b0;
        else i_addr = i_addr + 32'd4;
      end
      tick();
    end
    inputs_idle();
    chk("starve.max_data_between_fetches_le2", 32'(max_d <= 2), 32'd1);
    chk("starve.fetch_progress", 32'(i_done >= 5), 32'd1);
    chk("starve.data_progress", 32'(d_done >= 5), 32'd1);
    tick(); tick();

    // --- reset during D_BUSY aborts silently ---
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h700; d_wdata = 32'h99;
    tick();
    settle();
    chk("rst.busy.mem_req", mem_req, 1'b1);
    tick();
    reset = 1'b0; d_req = 1'b0;
    tick();
    settle();
    chk_out("rst.first", '0, '0, '0, '0, '0, '0, '0, '0, '0);
    mem_ack = 1'b1; mem_rdata = 32'h31415926;
    tick(); tick();
    mem_ack = 1'b0;
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      settle();
      chk($sformatf("rst.after%0d", c), {mem_req, d_ready, i_ready, err}, 4'b0000);
      tick();
    end

    // --- randomized traffic against the reference model ---
    reset = 1'b0;
    tick();
    reset = 1'b1;
    model_reset();
    ip = 1'b0; dp = 1'b0; ia_r = '0; da_r = '0; dd_r = '0; dw_r = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (e_ir) ip = 1'b0;
      if (!ip && $urandom_range(0, 2) == 0) begin ip = 1'b1; ia_r = $urandom; end
      if (e_dr) dp = 1'b0;
      if (!dp && $urandom_range(0, 2) == 0) begin
        dp = 1'b1; da_r = $urandom; dd_r = $urandom; dw_r = 1'($urandom_range(0, 1));
      end
      i_req = ip; i_addr = ia_r;
      d_req = dp; d_we = dw_r; d_addr = da_r; d_wdata = dd_r;
      mem_rdata = $urandom;
      if (own != 0) mem_ack = (k == dly);
      else          mem_ack = ($urandom_range(0, 7) == 0);
      settle();
      chk_out($sformatf("rnd%0d", c), e_mr, e_mw, e_ma, e_md, e_ir, e_dr, e_er, e_ird, e_drd);

      n_mr = e_mr; n_mw = e_mw; n_ma = e_ma; n_md = e_md;
      n_ird = e_ird; n_drd = e_drd; n_ir = 1'b0; n_dr = 1'b0; n_er = 1'b0;
      gi = 1'b0; gd = 1'b0;
      if (own == 0) begin
        im = i_req && !e_ir;
        dm = d_req && !e_dr;
        if (im && st == SL) gi = 1'b1;
        else if (dm)        gd = 1'b1;
        else if (im)        gi = 1'b1;
        if (gi || gd) begin
          own = gi ? 1 : 2;
          own_we = gd && d_we;
          k = 1;
          dly = $urandom_range(1, 10);
          n_mr = 1'b1;
          n_mw = own_we;
          n_ma = gd ? d_addr : i_addr;
          n_md = gd ? d_wdata : 32'h0;
        end
      end else if (mem_ack || k == TO) begin
        n_mr = 1'b0;
        n_er = !mem_ack;
        if (own == 1) begin
          n_ir = 1'b1;
          n_ird = mem_ack ? mem_rdata : 32'h0;
        end else begin
          n_dr = 1'b1;
          if (!mem_ack)     n_drd = 32'h0;
          else if (!own_we) n_drd = mem_rdata;
        end
        own = 0;
      end else begin
        k++;
      end
      if (gi || !i_req) st = 0;
      else if (st < SL) st++;

      tick();
      e_mr = n_mr; e_mw = n_mw; e_ma = n_ma; e_md = n_md;
      e_ir = n_ir; e_dr = n_dr; e_er = n_er; e_ird = n_ird; e_drd = n_drd;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported backing memory between the pipeline's instruction-fetch requester (read-only) and data-memory requester (read/write).
- Sits between the IF/MEM stages of the 5-stage core and a multi-cycle memory with a request/ack handshake.
- Stalls requesters while a transaction is pending.
- Data port has priority; a starvation counter guarantees fetch forward progress; a timeout aborts hung transactions.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, fetch-wait cycles after which fetch wins arbitration; range 1..15.
- TIMEOUT, 64, max BUSY cycles without mem_ack before abort; 0 disables; range 0..255.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-low: state cleared on a rising clk edge while reset==0.
- i_req  in  1  fetch request; held with i_addr stable until i_ready.
- i_addr  in  ADDR_W  fetch address.
- i_rdata  out  DATA_W  fetch read data, valid when i_ready.
- i_ready  out  1  one-cycle completion pulse for fetch.
- i_stall  out  1  i_req & ~i_ready (combinational).
- d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_ready.
- d_we  in  1  1=write, 0=read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_rdata  out  DATA_W  data read data, valid when d_ready.
- d_ready  out  1  one-cycle completion pulse for data.
- d_stall  out  1  d_req & ~d_ready (combinational).
- err  out  1  pulses with i_ready/d_ready when the completion was a timeout abort.
- mem_req  out  1  memory request, held high through the transaction.
- mem_we  out  1  latched write enable.
- mem_addr  out  ADDR_W  latched address.
- mem_wdata  out  DATA_W  latched write data.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion from memory.

Behaviour:
- States: IDLE, I_BUSY, D_BUSY.
- Reset values: state=IDLE; all outputs 0; rdata registers 0; starvation and timeout counters 0.
- Reset mid-transaction aborts it silently: no ready pulse, mem_req low after the edge.
- Arbitration in IDLE, in order:
  - A requester whose ready is high this cycle is masked, so its still-held req is not re-granted.
  - If i_req and starve_cnt==STARVE_LIMIT: grant I.
  - Else if d_req: grant D.
  - Else if i_req: grant I.
  - Else stay in IDLE.
- Grant: at the edge, latch addr/we/wdata into mem_* and go to I_BUSY or D_BUSY; mem_req=1 from the next cycle. Fetch grants drive mem_we=0 and mem_wdata=0.
- Latency: req first seen in cycle N → mem_req high from N+1 → mem_ack in cycle M (M≥N+1) → ready pulse and rdata in M+1, with state=IDLE and mem_req=0 in M+1. Minimum round trip: 2 cycles.
- Back-to-back: a new grant may be decided in cycle M+1, so mem_req rises again at M+2. There is one idle memory cycle between transactions.
- Read completion: owner's rdata register ← mem_rdata at the ack edge.
- Write completion: d_ready pulses; d_rdata unchanged.
- The non-owner's rdata is never modified.
- starve_cnt:
  - +1 on each cycle with i_req=1 and no I grant, saturating at STARVE_LIMIT.
  - Cleared on I grant.
  - Cleared when i_req=0.
- Timeout: counter cleared on grant, +1 each BUSY cycle without ack. When TIMEOUT≠0 and it reaches TIMEOUT:
  - Return to IDLE and drop mem_req.
  - Pulse the owner's ready with err=1; owner's rdata ← 0.
- mem_ack in the same cycle the counter reaches TIMEOUT counts as normal completion: err=0.
- mem_ack while IDLE is ignored, with no state or output change.
- Simultaneous i_req and d_req in IDLE: D wins unless starve_cnt==STARVE_LIMIT.
- Requester dropping req mid-transaction is illegal; the transaction still completes and the ready pulse is emitted.

Test Plan:
- Reset held low 3 cycles during D_BUSY → mem_req=0, d_ready never pulses, err=0, all outputs 0 after the first edge with reset low.
- i_req at cycle 0, addr 0x40; mem_ack at cycle 3 with rdata 0xDEADBEEF → mem_req high cycles 1–3, mem_addr=0x40, mem_we=0, i_ready=1 and i_rdata=0xDEADBEEF at cycle 4 only.
- i_req and d_req both at cycle 0 (d write 0x80←0x12345678), memory acks 1 cycle after each request → data granted first (mem_we=1, mem_wdata=0x12345678), d_ready at 3, fetch mem_req rises at 4, i_ready at 6.
- d_req held continuously with new addresses, i_req held, STARVE_LIMIT=4, each ack 1 cycle later → fetch granted once starve_cnt hits 4 despite pending d_req, and never waits more than 2 data transactions.
- TIMEOUT=8, d read granted, mem_ack never arrives → mem_req drops after 8 BUSY cycles, d_ready=1 and err=1 for one cycle, d_rdata=0, next request is granted normally.
- Spurious mem_ack pulses while IDLE → no ready pulse, rdata unchanged, state stays IDLE.
